// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the 8-bit signed adder stage and the result
// accumulator. The master side is the upstream adder plus the downstream
// consumer of block totals; the slave side is the accumulator itself.
interface adder_result_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_WIDTH = 16
);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [CNT_W-1:0]     out_ovf_cnt;
  logic                 err;

  modport master (
    output in_valid, in_a, in_b, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf_cnt, err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_ovf_cnt, err
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates BLOCK_LEN (a, b, sum) beats from the signed adder stage,
// counts signed-overflow beats, flags sum mismatches (sticky until reset)
// and presents each block total on a valid/ready output.
// Optional build macro: ADDER_RESULT_SAT_EN -- when defined, overflowing
// samples are saturated to the signed extreme instead of wrapping.
module adder_result_accumulator #(
  parameter int WIDTH     = 8,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst,
  adder_result_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_LEN - 1);

  logic [0:0]           state_q,     state_d;
  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]     beatCnt_q,   beatCnt_d;
  logic [CNT_W-1:0]     ovfCnt_q,    ovfCnt_d;
  logic [ACC_WIDTH-1:0] outAcc_q,    outAcc_d;
  logic [CNT_W-1:0]     outOvfCnt_q, outOvfCnt_d;
  logic                 err_q,       err_d;

  logic                 collecting;
  logic                 accept;
  logic                 ovf;
  logic                 mismatch;
  logic [WIDTH-1:0]     wrapSum;
  logic [WIDTH-1:0]     sample;
  logic [ACC_WIDTH-1:0] accSum;
  logic [CNT_W-1:0]     ovfSum;

  assign collecting = (state_q == COLLECT);
  assign accept     = bus.in_valid && collecting;
  assign wrapSum    = bus.in_a + bus.in_b;
  assign ovf        = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                      (bus.in_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
  assign mismatch   = (bus.in_sum != wrapSum);

  // Pick the sample that enters the accumulator: raw sum, or saturated on overflow
  always_comb begin
    sample = bus.in_sum;
`ifdef ADDER_RESULT_SAT_EN
    if (ovf) begin
      sample = bus.in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign accSum = acc_q + {{(ACC_WIDTH-WIDTH){sample[WIDTH-1]}}, sample};
  assign ovfSum = ovfCnt_q + {{(CNT_W-1){1'b0}}, ovf};

  // Next-state logic for collection, block hand-off and the sticky error
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beatCnt_d   = beatCnt_q;
    ovfCnt_d    = ovfCnt_q;
    outAcc_d    = outAcc_q;
    outOvfCnt_d = outOvfCnt_q;
    err_d       = err_q;

    if (accept && mismatch) begin
      err_d = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (beatCnt_q == LAST_BEAT) begin
            outAcc_d    = accSum;
            outOvfCnt_d = ovfSum;
            acc_d       = '0;
            beatCnt_d   = '0;
            ovfCnt_d    = '0;
            state_d     = EMIT;
          end else begin
            acc_d     = accSum;
            beatCnt_d = beatCnt_q + 1'b1;
            ovfCnt_d  = ovfSum;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      acc_q       <= '0;
      beatCnt_q   <= '0;
      ovfCnt_q    <= '0;
      outAcc_q    <= '0;
      outOvfCnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beatCnt_q   <= beatCnt_d;
      ovfCnt_q    <= ovfCnt_d;
      outAcc_q    <= outAcc_d;
      outOvfCnt_q <= outOvfCnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = collecting;
  assign bus.out_valid   = (state_q == EMIT);
  assign bus.out_acc     = outAcc_q;
  assign bus.out_ovf_cnt = outOvfCnt_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Testbench for adder_result_accumulator: a driver feeds beats and keeps a
// block-level reference model that queues expected totals; a negedge
// monitor pops and compares whenever a new total is presented.
module tb_adder_result_accumulator;
  localparam int W    = 8;
  localparam int BL   = 4;
  localparam int AW   = 16;
  localparam int HALF = 2 ** (W - 1);
  localparam int FULL = 2 ** W;

  typedef struct {
    int acc;
    int ovf;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   readyMode;
  logic randBit;

  expT  expQ[$];
  expT  cur;
  logic shown;
  int   blockSum;
  int   blockOvf;
  int   blockBeats;
  logic expErr;
  int   checks;
  int   passes;

  always #5 clk = ~clk;

  adder_result_accumulator_if #(.WIDTH(W), .BLOCK_LEN(BL), .ACC_WIDTH(AW)) bus ();

  adder_result_accumulator #(.WIDTH(W), .BLOCK_LEN(BL), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Downstream ready: forced low, forced high, or random per cycle
  assign bus.out_ready = (readyMode == 2) ? randBit : (readyMode == 1);

  always @(posedge clk) begin
    #1;
    randBit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual == required) passes++;
    else $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
  endtask

  function automatic int wrapW(input int v);
    return ((v + HALF) % FULL + FULL) % FULL - HALF;
  endfunction

  // Reference model: one accepted beat, returns 1 when a block completes
  task automatic modelAccept(input int a, input int b, input int s, output bit done);
    bit ovf;
    int sample;
    ovf = ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    if (wrapW(a + b) != s) expErr = 1'b1;
    sample = s;
`ifdef ADDER_RESULT_SAT_EN
    if (ovf) sample = (a >= 0) ? HALF - 1 : -HALF;
`endif
    blockSum += sample;
    blockOvf += ovf ? 1 : 0;
    blockBeats++;
    done = 1'b0;
    if (blockBeats == BL) begin
      expQ.push_back('{acc: blockSum, ovf: blockOvf});
      blockSum   = 0;
      blockOvf   = 0;
      blockBeats = 0;
      done       = 1'b1;
    end
  endtask

  // Present one beat and hold it until accepted; called at posedge+1
  task automatic applyStimulus(input int a, input int b, input int s);
    bit accepted;
    bit done;
    bus.in_a     = a[W-1:0];
    bus.in_b     = b[W-1:0];
    bus.in_sum   = s[W-1:0];
    bus.in_valid = 1'b1;
    accepted     = 1'b0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted a=%0d b=%0d", a, b);
    end else begin
      modelAccept(a, b, s, done);
      if (done) checkOutput("valid_latency", int'(bus.out_valid), 1);
    end
  endtask

  task automatic randomBeat();
    int a;
    int b;
    a = int'($urandom_range(0, FULL - 1)) - HALF;
    b = int'($urandom_range(0, FULL - 1)) - HALF;
    if ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    applyStimulus(a, b, wrapW(a + b));
  endtask

  task automatic doReset();
    rst        = 1'b1;
    blockSum   = 0;
    blockOvf   = 0;
    blockBeats = 0;
    expErr     = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    readyMode = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: checks err every cycle and each newly presented block total
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("err", int'(bus.err), int'(expErr));
      if (bus.out_valid) begin
        if (!shown) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_output actual=out_valid required=no_output");
          end else begin
            cur = expQ.pop_front();
            checkOutput("out_acc", int'($signed(bus.out_acc)), cur.acc);
            checkOutput("out_ovf_cnt", int'(bus.out_ovf_cnt), cur.ovf);
          end
          shown = 1'b1;
        end else begin
          checkOutput("out_acc_stable", int'($signed(bus.out_acc)), cur.acc);
          checkOutput("out_ovf_cnt_stable", int'(bus.out_ovf_cnt), cur.ovf);
        end
      end else begin
        shown = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    passes       = 0;
    shown        = 1'b0;
    expErr       = 1'b0;
    blockSum     = 0;
    blockOvf     = 0;
    blockBeats   = 0;
    readyMode    = 1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_sum   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_in_ready", int'(bus.in_ready), 1);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_acc", int'($signed(bus.out_acc)), 0);
    checkOutput("rst_out_ovf_cnt", int'(bus.out_ovf_cnt), 0);
    checkOutput("rst_err", int'(bus.err), 0);

    $display("[TB] directed block with two positive overflows");
    applyStimulus(20, 34, 54);
    applyStimulus(56, 74, -126);
    applyStimulus(123, -1, 122);
    applyStimulus(72, 98, -86);
    drain();

    $display("[TB] negative overflow block");
    for (int i = 0; i < BL; i++) applyStimulus(-128, -1, 127);
    drain();

    $display("[TB] output backpressure");
    readyMode = 0;
    for (int i = 0; i < BL; i++) applyStimulus(5, 6, 11);
    bus.in_a     = 8'd1;
    bus.in_b     = 8'd2;
    bus.in_sum   = 8'd3;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    readyMode = 1;
    @(posedge clk);
    #1;
    readyMode    = 0;
    bus.in_valid = 1'b0;
    checkOutput("bp_release_out_valid", int'(bus.out_valid), 0);
    checkOutput("bp_release_in_ready", int'(bus.in_ready), 1);
    readyMode = 1;
    for (int i = 0; i < BL; i++) applyStimulus(1, 2, 3);
    drain();

    $display("[TB] random blocks with random downstream ready");
    readyMode = 2;
    for (int i = 0; i < 6 * BL; i++) randomBeat();
    drain();

    $display("[TB] reset in the middle of a block");
    applyStimulus(10, 10, 20);
    applyStimulus(10, 10, 20);
    doReset();
    for (int i = 0; i < BL; i++) applyStimulus(1, 1, 2);
    drain();

    $display("[TB] sum mismatch is sticky");
    applyStimulus(7, 2, 0);
    checkOutput("err_after_mismatch", int'(bus.err), 1);
    for (int i = 0; i < 2 * BL - 1; i++) randomBeat();
    drain();
    checkOutput("err_sticky", int'(bus.err), 1);
    doReset();
    checkOutput("err_cleared", int'(bus.err), 0);

    drain();
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("final_out_valid", int'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
